// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: first-word fall-through FIFO of instruction/PC+4 pairs between fetch and decode.
// Optional IFQ_STALL_CNT_EN adds StallCycles, a saturating count of fetch cycles blocked by a full queue.
module instr_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              IF_Valid,
    input  logic [31:0]       IF_Instr,
    input  logic [31:0]       IF_PCPlus4,
    output logic              IF_Ready,
    input  logic              ID_Stall,
    output logic              ID_Valid,
    output logic [31:0]       ID_Instr,
    output logic [31:0]       ID_PCPlus4,
    output logic [ADDR_W:0]   Count
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [31:0]       StallCycles
`endif
);
    logic [31:0]       r_instr [DEPTH];
    logic [31:0]       r_pc    [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full     = r_count == (ADDR_W+1)'(DEPTH);
    assign w_empty    = r_count == '0;
    assign w_push     = IF_Valid & ~w_full & ~Flush;
    assign w_pop      = ~w_empty & ~ID_Stall & ~Flush;
    assign IF_Ready   = ~w_full;
    assign ID_Valid   = ~w_empty;
    assign ID_Instr   = w_empty ? 32'h0 : r_instr[r_rd_ptr];
    assign ID_PCPlus4 = w_empty ? 32'h0 : r_pc[r_rd_ptr];
    assign Count      = r_count;

    // Flush only rewinds pointers; stale storage is unreachable once the count is zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= IF_Instr;
                r_pc[r_wr_ptr]    <= IF_PCPlus4;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop)
                r_count <= r_count + 1'b1;
            else if (~w_push & w_pop)
                r_count <= r_count - 1'b1;
        end
    end

`ifdef IFQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Survives Flush so the debug display accumulates across branches.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_stall_cnt <= '0;
        else if (IF_Valid & w_full & ~&r_stall_cnt)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign StallCycles = r_stall_cnt;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed plus randomized checks of instr_fetch_queue against a queue-based model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst, Flush, IF_Valid, ID_Stall;
    logic [31:0] IF_Instr, IF_PCPlus4;
    logic        IF_Ready, ID_Valid;
    logic [31:0] ID_Instr, ID_PCPlus4;
    logic [2:0]  Count;
`ifdef IFQ_STALL_CNT_EN
    logic [31:0] StallCycles;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [63:0] q[$];
    logic [31:0] stall_m = 0;

    always #5 Clk = ~Clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PCPlus4(IF_PCPlus4), .IF_Ready(IF_Ready),
        .ID_Stall(ID_Stall), .ID_Valid(ID_Valid), .ID_Instr(ID_Instr), .ID_PCPlus4(ID_PCPlus4),
        .Count(Count)
`ifdef IFQ_STALL_CNT_EN
        , .StallCycles(StallCycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("if_ready", {31'b0, IF_Ready}, {31'b0, q.size() < DEPTH});
        chk("id_valid", {31'b0, ID_Valid}, {31'b0, q.size() != 0});
        chk("id_instr", ID_Instr, q.size() != 0 ? q[0][63:32] : 32'h0);
        chk("id_pc", ID_PCPlus4, q.size() != 0 ? q[0][31:0] : 32'h0);
        chk("count", {29'b0, Count}, 32'(q.size()));
`ifdef IFQ_STALL_CNT_EN
        chk("stall_cycles", StallCycles, stall_m);
`endif
    endtask

    // Called at a negedge; checks state, drives one cycle of inputs, advances the model.
    task automatic step(input logic f, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic s);
        logic push, pop;
        check_all();
        Flush = f; IF_Valid = v; IF_Instr = ins; IF_PCPlus4 = pc; ID_Stall = s;
        push = v && q.size() < DEPTH && !f;
        pop  = q.size() != 0 && !s && !f;
        if (v && q.size() == DEPTH && stall_m != 32'hFFFF_FFFF) stall_m++;
        @(posedge Clk);
        if (f) q.delete();
        else begin
            if (pop) q.delete(0);
            if (push) q.push_back({ins, pc});
        end
        @(negedge Clk);
    endtask

    // Asserted between edges so an asynchronous reset is observable immediately.
    task automatic do_reset();
        Rst = 1'b1;
        q.delete();
        stall_m = 0;
        #1 check_all();
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Flush = 0; IF_Valid = 0; ID_Stall = 0; IF_Instr = 0; IF_PCPlus4 = 0;
        #12 check_all();
        @(negedge Clk);
        Rst = 1'b0;
        // 1: idle after reset
        step(0, 0, 0, 0, 0);
        // 2: single push, visible next cycle, popped the edge after
        step(0, 1, 32'h2008_0005, 32'h4, 0);
        chk("t2_valid", {31'b0, ID_Valid}, 32'h1);
        chk("t2_instr", ID_Instr, 32'h2008_0005);
        step(0, 0, 0, 0, 0);
        chk("t2_count", {29'b0, Count}, 32'h0);
        // 3: stalled decode, five pushes, fifth dropped
        for (int i = 1; i <= 5; i++) step(0, 1, 32'h100 + i, 32'h1000 + 4 * i, 1);
        chk("t3_ready", {31'b0, IF_Ready}, 32'h0);
        chk("t3_count", {29'b0, Count}, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", ID_Instr, 32'h100 + i);
            step(0, 0, 0, 0, 0);
        end
        // 4: steady push+pop at count 2, pointers wrap
        step(0, 1, 32'h200, 32'h2000, 1);
        step(0, 1, 32'h201, 32'h2004, 1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_order", ID_Instr, 32'h200 + i);
            step(0, 1, 32'h202 + i, 32'h2008 + 4 * i, 0);
            chk("t4_count", {29'b0, Count}, 32'h2);
        end
        // 5: flush at count 3 with a concurrent push
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h300, 32'h3000, 1);
        chk("t5_pre", {29'b0, Count}, 32'h3);
        step(1, 1, 32'hDEAD_BEEF, 32'h3004, 0);
        chk("t5_count", {29'b0, Count}, 32'h0);
        chk("t5_valid", {31'b0, ID_Valid}, 32'h0);
        chk("t5_instr", ID_Instr, 32'h0);
        // flush with stall, and from full
        for (int i = 0; i < 4; i++) step(0, 1, 32'h400 + i, 32'h4000, 1);
        step(1, 1, 32'h404, 32'h4004, 1);
        chk("t5_full_flush", {29'b0, Count}, 32'h0);
        // 6: stall counter, then mid-operation async reset
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 32'h500 + i, 32'h5000, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 32'h600 + i, 32'h6000, 1);
`ifdef IFQ_STALL_CNT_EN
        chk("t6_stall7", StallCycles, 32'd7);
`endif
        step(1, 0, 0, 0, 0);
`ifdef IFQ_STALL_CNT_EN
        chk("t6_after_flush", StallCycles, 32'd7);
`endif
        step(0, 1, 32'h700, 32'h7000, 1);
        do_reset();
`ifdef IFQ_STALL_CNT_EN
        chk("t6_after_rst", StallCycles, 32'd0);
`endif
        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            if (n % 131 == 130) do_reset();
            step($urandom_range(15) == 0, $urandom_range(9) < 7, $urandom, $urandom,
                 $urandom_range(9) < 4);
        end
        check_all();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
